// File: rtl/background_control_pkg.sv
// Shared types and constants for the 4-layer tiled background renderer.
package bg_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, DRAW} state_t;

  localparam int NUM_LAYERS      = 4;
  localparam int TILES_PER_LAYER = 4;
  localparam int PIX_PER_TILE    = 4;
  localparam int FETCH_CYCLES    = 32;
  localparam int DRAW_CYCLES     = 16;

  typedef logic [1:0] colour_t;
  localparam colour_t TRANSPARENT = 2'b00;

  // One bitplane row per tile; bit 3 is the leftmost pixel.
  typedef logic [PIX_PER_TILE-1:0] row_t;
  typedef row_t [TILES_PER_LAYER-1:0] layerRows_t;
  typedef layerRows_t [NUM_LAYERS-1:0] rowStore_t;
  typedef logic [NUM_LAYERS-1:0][3:0] panSet_t;

endpackage

// File: rtl/background_control_if.sv
// Memory-side bus of the background renderer: char map, tile rows and palette.
interface background_control_if;
  logic [3:0] charAddrOut;
  logic [3:0] charDataIn;
  logic [3:0] tileLowAddrOut;
  logic [3:0] tileHighAddrOut;
  logic [3:0] tileLowDataIn;
  logic [3:0] tileHighDataIn;
  logic [3:0] palAddrOut;
  logic [3:0] palDataIn;

  modport master (
    output charAddrOut, tileLowAddrOut, tileHighAddrOut, palAddrOut,
    input  charDataIn, tileLowDataIn, tileHighDataIn, palDataIn
  );

  modport slave (
    input  charAddrOut, tileLowAddrOut, tileHighAddrOut, palAddrOut,
    output charDataIn, tileLowDataIn, tileHighDataIn, palDataIn
  );
endinterface

// File: rtl/background_control_pixel_select.sv
// Combinational pixel resolver: per-layer pan wrap, bit select and layer priority.
module bg_pixel_select
  import bg_pkg::*;
(
  input  rowStore_t  lowRows,
  input  rowStore_t  highRows,
  input  logic [3:0] x,
  input  panSet_t    pans,
  output logic [3:0] palAddr
);

  logic [3:0] pos    [NUM_LAYERS];
  logic [1:0] bitSel [NUM_LAYERS];
  colour_t    col    [NUM_LAYERS];

  for (genvar l = 0; l < NUM_LAYERS; l++) begin : gLayer
    // 4-bit add wraps the scroll around the 16-pixel line.
    assign pos[l]    = x + pans[l];
    assign bitSel[l] = 2'd3 - pos[l][1:0];
    assign col[l]    = {highRows[l][pos[l][3:2]][bitSel[l]],
                        lowRows[l][pos[l][3:2]][bitSel[l]]};
  end

  // Walk from lowest to highest priority so layer 0 wins last.
  always_comb begin
    palAddr = '0;
    for (int l = NUM_LAYERS - 1; l >= 0; l--) begin
      if (col[l] != TRANSPARENT) palAddr = {2'(l), col[l]};
    end
  end

endmodule

// File: rtl/background_control.sv
// Per-scanline 4-layer tiled background renderer (FETCH then DRAW of 16 pixels).
// Define BG_PAN_EN to enable per-layer horizontal pan; otherwise pans are ignored.
module background_control
  import bg_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 lineStarting,
  input  logic [3:0]           layer0Pan,
  input  logic [3:0]           layer1Pan,
  input  logic [3:0]           layer2Pan,
  input  logic [3:0]           layer3Pan,
  background_control_if.master bus,
  output logic [3:0]           pixelOut
);

  state_t     state, nextState;
  logic [4:0] cnt, nextCnt;
  logic [3:0] tileIdx;
  logic [3:0] slot;
  logic [3:0] selAddr;
  rowStore_t  lowStore, highStore;
  panSet_t    pans;

  // Fetch slot s occupies cnt = 2s (char read) and 2s+1 (row read).
  assign slot = cnt[4:1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nextState;
      cnt   <= nextCnt;
    end
  end

  always_comb begin
    nextState = state;
    nextCnt   = cnt + 5'd1;
    if (lineStarting) begin
      nextState = FETCH;
      nextCnt   = '0;
    end else begin
      unique case (state)
        IDLE:  nextCnt = '0;
        FETCH: if (cnt == 5'(FETCH_CYCLES - 1)) begin
                 nextState = DRAW;
                 nextCnt   = '0;
               end
        DRAW:  if (cnt == 5'(DRAW_CYCLES - 1)) begin
                 nextState = IDLE;
                 nextCnt   = '0;
               end
        default: begin
                 nextState = IDLE;
                 nextCnt   = '0;
               end
      endcase
    end
  end

  always_comb begin
    bus.charAddrOut     = '0;
    bus.tileLowAddrOut  = '0;
    bus.tileHighAddrOut = '0;
    bus.palAddrOut      = '0;
    if (state == FETCH) begin
      if (!cnt[0]) bus.charAddrOut = slot;
      else begin
        bus.tileLowAddrOut  = tileIdx;
        bus.tileHighAddrOut = tileIdx;
      end
    end else if (state == DRAW) begin
      bus.palAddrOut = selAddr;
    end
  end

  // ---- fetch capture and output pixel register ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pixelOut  <= '0;
      tileIdx   <= '0;
      lowStore  <= '0;
      highStore <= '0;
    end else begin
      pixelOut <= (state == DRAW && !lineStarting) ? bus.palDataIn : 4'd0;
      if (state == FETCH) begin
        if (!cnt[0]) tileIdx <= bus.charDataIn;
        else begin
          lowStore[slot[3:2]][slot[1:0]]  <= bus.tileLowDataIn;
          highStore[slot[3:2]][slot[1:0]] <= bus.tileHighDataIn;
        end
      end
    end
  end

`ifdef BG_PAN_EN
  always_ff @(posedge clk) begin
    if (!rst_n)            pans <= '0;
    else if (lineStarting) pans <= {layer3Pan, layer2Pan, layer1Pan, layer0Pan};
  end
`else
  logic unusedPans;
  assign unusedPans = ^{layer3Pan, layer2Pan, layer1Pan, layer0Pan};
  assign pans       = '0;
`endif

  bg_pixel_select uSelect (
    .lowRows  (lowStore),
    .highRows (highStore),
    .x        (cnt[3:0]),
    .pans     (pans),
    .palAddr  (selAddr)
  );

endmodule

// File: tb/tb_background_control.sv
// Self-checking bench for background_control: line-level model plus directed literal checks.
module tb_background_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       lineStarting = 1'b0;
  logic [3:0] pan [4];
  logic [3:0] pixelOut;
  logic [3:0] charMap [16];
  logic [3:0] lowMem  [16];
  logic [3:0] highMem [16];
  logic [3:0] expPal  [16];
  int         k = -1;
  bit         armed = 1'b0;
  int         checks = 0;
  int         errors = 0;

  background_control_if bus();

  always #5 clk = ~clk;

  background_control dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .lineStarting (lineStarting),
    .layer0Pan    (pan[0]),
    .layer1Pan    (pan[1]),
    .layer2Pan    (pan[2]),
    .layer3Pan    (pan[3]),
    .bus          (bus),
    .pixelOut     (pixelOut)
  );

  // Memory models: combinational, same-cycle data.
  assign bus.charDataIn     = charMap[bus.charAddrOut];
  assign bus.tileLowDataIn  = lowMem[bus.tileLowAddrOut];
  assign bus.tileHighDataIn = highMem[bus.tileHighAddrOut];
  assign bus.palDataIn      = bus.palAddrOut + 4'd1;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, k, act, exp);
    end
  endtask

  // Model: render each layer's full 16-pixel line, then scroll and layer it.
  function automatic void buildLine();
    logic [1:0] col [4][16];
    logic [3:0] idx;
    int         pos;
    for (int l = 0; l < 4; l++)
      for (int t = 0; t < 4; t++) begin
        idx = charMap[l * 4 + t];
        for (int j = 0; j < 4; j++)
          col[l][t * 4 + j] = {highMem[idx][3 - j], lowMem[idx][3 - j]};
      end
    for (int x = 0; x < 16; x++) begin
      expPal[x] = 4'd0;
      for (int l = 3; l >= 0; l--) begin
`ifdef BG_PAN_EN
        pos = (x + int'(pan[l])) % 16;
`else
        pos = x;
`endif
        if (col[l][pos] != 2'b00) expPal[x] = {2'(l), col[l][pos]};
      end
    end
  endfunction

  // Cycle number relative to the last accepted line start (-1: none since reset).
  always @(posedge clk) begin
    armed <= 1'b1;
    if (!rst_n) k <= -1;
    else if (lineStarting) begin
      k <= 1;
      buildLine();
    end else if (k >= 1) k <= k + 1;
  end

  always @(negedge clk) begin
    logic [3:0] eChar, eTile, ePal, ePix;
    if (armed) begin
      eChar = (k >= 1 && k <= 31 && (k % 2) == 1) ? 4'((k - 1) / 2) : 4'd0;
      eTile = (k >= 2 && k <= 32 && (k % 2) == 0) ? charMap[(k - 2) / 2] : 4'd0;
      ePal  = (k >= 33 && k <= 48) ? expPal[k - 33] : 4'd0;
      ePix  = (k >= 34 && k <= 49) ? expPal[k - 34] + 4'd1 : 4'd0;
      check("charAddr", bus.charAddrOut, eChar);
      check("tileLowAddr", bus.tileLowAddrOut, eTile);
      check("tileHighAddr", bus.tileHighAddrOut, eTile);
      check("palAddr", bus.palAddrOut, ePal);
      check("pixelOut", pixelOut, ePix);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    lineStarting = 1'b1;
    tick();
    lineStarting = 1'b0;
  endtask

  task automatic waitK(input int target);
    int n = 0;
    @(negedge clk);
    while (k != target && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (k != target) begin
      checks++;
      errors++;
      $display("FAIL waitK timeout actual=%0d required=%0d", k, target);
    end
  endtask

  task automatic clearMem();
    for (int i = 0; i < 16; i++) begin
      charMap[i] = 4'(i);
      lowMem[i]  = 4'd0;
      highMem[i] = 4'd0;
    end
  endtask

  initial begin
    for (int l = 0; l < 4; l++) pan[l] = 4'd0;
    clearMem();

    // Reset dominates lineStarting.
    rst_n = 1'b0;
    lineStarting = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("rst pixelOut", pixelOut, 4'h0);
    check("rst charAddr", bus.charAddrOut, 4'h0);
    check("rst tileLowAddr", bus.tileLowAddrOut, 4'h0);
    tick();
    rst_n = 1'b1;
    lineStarting = 1'b0;
    tick();

    // Fetch addressing.
    for (int i = 0; i < 16; i++) charMap[i] = 4'(i) ^ 4'h5;
    pulse();
    waitK(3);  check("fetch char slot1", bus.charAddrOut, 4'h1);
    waitK(4);  check("fetch tileLow slot1", bus.tileLowAddrOut, 4'h4);
               check("fetch tileHigh slot1", bus.tileHighAddrOut, 4'h4);
    waitK(32); check("fetch tile slot15", bus.tileLowAddrOut, 4'hA);
    waitK(52);

    // Single layer: layer 0 colour 01 everywhere.
    clearMem();
    for (int i = 0; i < 4; i++) lowMem[i] = 4'hF;
    pulse();
    check("model single x0", expPal[0], 4'h1);
    check("model single x15", expPal[15], 4'h1);
    waitK(34); check("single pix first", pixelOut, 4'h2);
    waitK(40); check("single palAddr", bus.palAddrOut, 4'h1);
    waitK(49); check("single pix last", pixelOut, 4'h2);
    waitK(50); check("single pix after", pixelOut, 4'h0);
    waitK(52);

    // Priority: transparent layer 0 exposes layer 1 colour 11.
    clearMem();
    for (int i = 4; i < 8; i++) begin
      lowMem[i]  = 4'hF;
      highMem[i] = 4'hF;
    end
    pulse();
    waitK(36); check("prio layer1", bus.palAddrOut, 4'h7);
    waitK(52);
    for (int i = 0; i < 4; i++) highMem[i] = 4'hF;
    pulse();
    check("model prio layer0", expPal[3], 4'h2);
    waitK(36); check("prio layer0", bus.palAddrOut, 4'h2);
    waitK(37); check("prio layer0 pix", pixelOut, 4'h3);
    waitK(52);

    // Pan wrap on layer 0.
    clearMem();
    lowMem[0] = 4'h8;
    pan[0] = 4'hF;
    pulse();
`ifdef BG_PAN_EN
    waitK(33); check("pan x0", bus.palAddrOut, 4'h0);
    waitK(34); check("pan x1", bus.palAddrOut, 4'h1);
    waitK(35); check("pan x2", bus.palAddrOut, 4'h0);
`else
    waitK(33); check("nopan x0", bus.palAddrOut, 4'h1);
    waitK(34); check("nopan x1", bus.palAddrOut, 4'h0);
`endif
    waitK(52);

    // Mixed content with distinct pans on every layer.
    for (int i = 0; i < 16; i++) begin
      charMap[i] = 4'(i * 7 + 3);
      lowMem[i]  = 4'(i * 3 + 1);
      highMem[i] = ~4'(i * 5);
    end
    pan[0] = 4'h3; pan[1] = 4'h7; pan[2] = 4'hA; pan[3] = 4'h5;
    pulse();
    waitK(52);

    // Restart during DRAW at x=5.
    pulse();
    waitK(38);
    pulse();
    @(negedge clk);
    check("restart charAddr", bus.charAddrOut, 4'h0);
    check("restart pixelOut", pixelOut, 4'h0);
    waitK(52);

    // Reset mid-line clears outputs.
    pulse();
    waitK(40);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("midreset pixelOut", pixelOut, 4'h0);
    check("midreset palAddr", bus.palAddrOut, 4'h0);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/background_control.md
Name: background_control

Overview:
- Per-scanline renderer for a 4-layer tiled background, 16 pixels per line.
- A `lineStarting` pulse starts a FETCH phase, which reads each layer's 4 tile indices and their 2-bitplane tile rows from external memories.
- A DRAW phase then outputs 16 palette-resolved pixels, with per-layer horizontal pan and layer priority.
- Sits between the video timing generator and the char/tile/palette RAMs; `pixelOut` feeds the video mixer.

Parameters:
- None. All buses are fixed at 4 bits, 4 layers, 4 tiles per layer, 4 pixels per tile.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- lineStarting  in  1  one-cycle pulse; starts line processing.
- layer0Pan..layer3Pan  in  4 each  horizontal pixel scroll per layer (0..15).
- charAddrOut  out  4  char-map address {layer[1:0], tile[1:0]}.
- charDataIn  in  4  tile index returned by the char map; combinational, valid in the same cycle.
- tileLowAddrOut  out  4  bitplane-0 row address (equals the tile index).
- tileHighAddrOut  out  4  bitplane-1 row address (equals the tile index).
- tileLowDataIn  in  4  bitplane-0 row; bit3 is the leftmost pixel; same-cycle valid.
- tileHighDataIn  in  4  bitplane-1 row; same-cycle valid.
- palAddrOut  out  4  palette address {layer[1:0], colour[1:0]}.
- palDataIn  in  4  palette colour; same-cycle valid.
- pixelOut  out  4  registered output pixel.

Behaviour:
- Reset (rst_n low at a clock edge): state=IDLE; all outputs and stored tile rows cleared to 0.
- States: IDLE, FETCH, DRAW.
- Start of line: the edge that samples `lineStarting`=1 is cycle 0.
  - At that edge, latch all four pans and enter FETCH.
- FETCH, cycles 1..32: 16 slots, s=0..15, 2 cycles each.
  - Cycle 2s+1: charAddrOut=s, i.e. layer=s[3:2], tile=s[1:0]. Capture charDataIn.
  - Cycle 2s+2: tileLowAddrOut=tileHighAddrOut=captured index. Capture low/high rows into store[layer][tile].
- DRAW, cycles 33..48: x = cycle−33.
  - Per layer L: p = (x + pan_L) mod 16 (4-bit wrap); b = 3−p[1:0].
  - colour_L = {high[L][p[3:2]][b], low[L][p[3:2]][b]}.
  - Priority: layer 0 highest. Colour 00 is transparent.
  - palAddrOut = {L, colour_L} for the first non-transparent layer; if all layers are transparent, palAddrOut = 0 (backdrop).
  - palAddrOut is combinational; pixelOut <= palDataIn at the end of the cycle. Pixel x is therefore visible in cycle x+34.
- After cycle 48: return to IDLE. pixelOut is 0 from cycle 50.
- Address outputs are 0 in any cycle where they are not in use; palAddrOut is 0 outside DRAW.
- `lineStarting` asserted in FETCH or DRAW: abort and restart at FETCH slot 0, re-latching pans. pixelOut <= 0 at that edge.
- Reset has priority over `lineStarting`. Reset mid-line returns to IDLE with outputs cleared.

Optional Feature:
- Macro BG_PAN_EN.
  - Defined: pans are applied as above.
  - Undefined: pans are ignored (p = x) and the pan latches are removed; port list unchanged.

Decomposition:
- Shared package bg_pkg holds:
  - state enum (IDLE, FETCH, DRAW)
  - constants NUM_LAYERS=4, TILES_PER_LAYER=4, PIX_PER_TILE=4, FETCH_CYCLES=32, DRAW_CYCLES=16
  - colour type (2-bit) and transparent constant 2'b00
- One natural sub-module: bg_pixel_select. It is combinational: stored rows + x + pans -> palAddrOut (wrap, bit select, priority).

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with lineStarting=1 -> all outputs 0, no fetch addresses issued.
- Fetch addressing: model charData=addr^4'h5; pulse lineStarting -> charAddrOut=0..F on odd cycles 1..31; tile addresses 5,4,7,6,... on even cycles 2..32.
- Single layer: layer0 rows low=F/high=0, other layers 0, palData=addr+1 -> palAddrOut=4'h1, pixelOut=4'h2 for cycles 34..49, then 0.
- Priority/transparency: layer0 colour 00, layer1 low=F/high=F -> palAddrOut=4'h7 for all x. Add layer0 colour 10 -> palAddrOut=4'h2.
- Pan wrap (BG_PAN_EN): layer0Pan=F, layer0 tile0 low=8, all else 0 -> x=1 palAddrOut=4'h1; every other x palAddrOut=0.
- Restart: pulse lineStarting at DRAW x=5 -> next cycle charAddrOut=0, pixelOut=0, full sequence repeats.
